// File: rtl/fixed_residual_fork.sv
// Purpose: fork one fixed-point vector stream into a main-path copy (branch 0,
//          single-entry output register) and a skip-path copy (branch 1, FWFT FIFO).
// Latency: 1 cycle on both branches. Backpressure: input stalls when branch 0 is
//          full and not draining, or when the skip FIFO is full.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   data_in_0 / _valid / _ready       input beat, N elements of PREC_0 bits
//   data_out_0 / _valid / _ready      main-path beat
//   data_out_1 / _valid / _ready      skip-path beat (FIFO head)
//   skip_count                        skip FIFO occupancy
module fixed_residual_fork #(
  parameter int DATA_IN_0_PRECISION_0      = 16,
  parameter int DATA_IN_0_PRECISION_1      = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SKIP_FIFO_DEPTH             = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_1 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  output logic data_out_1_valid,
  input  logic data_out_1_ready,
  output logic [$clog2(SKIP_FIFO_DEPTH+1)-1:0] skip_count
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int D  = SKIP_FIFO_DEPTH;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  // Fraction width and tensor sizes only describe the data; they never change
  // the hardware. A fraction wider than the element is a configuration error,
  // surfaced as an elaboration-time empty block name for easy spotting.
  if (DATA_IN_0_PRECISION_1 > W || DATA_IN_0_TENSOR_SIZE_DIM_0 < 1 ||
      DATA_IN_0_TENSOR_SIZE_DIM_1 < 1) begin : g_bad_info_params
  end

  typedef logic [N-1:0][W-1:0] beat_t;

  beat_t          in_beat;
  beat_t          out0_q;
  logic           f0;
  beat_t          mem [D];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic fifo_full;
  logic fifo_nonempty;
  logic accept;
  logic pop0;
  logic pop1;

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < N; i++) begin
      in_beat[i] = data_in_0[i];
    end
  end

  assign fifo_full     = (skip_count == CW'(D));
  assign fifo_nonempty = (skip_count != '0);

  // Fullness is judged on the registered count only, so a same-cycle skip pop
  // does not open the input; this keeps data_out_1_ready off the ready path.
  assign data_in_0_ready = !rst && (!f0 || data_out_0_ready) && !fifo_full;

  assign accept = data_in_0_valid && data_in_0_ready;
  assign pop0   = f0 && data_out_0_ready;
  assign pop1   = fifo_nonempty && data_out_1_ready;

  assign data_out_0_valid = f0;
  assign data_out_1_valid = fifo_nonempty;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_out_0[i] = out0_q[i];
      data_out_1[i] = fifo_nonempty ? mem[rd_ptr][i] : '0;
    end
  end

  // Branch 0 register and FIFO control.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q     <= '0;
      f0         <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      skip_count <= '0;
    end else begin
      if (accept) begin
        out0_q <= in_beat;
        f0     <= 1'b1;
      end else if (pop0) begin
        f0 <= 1'b0;
      end

      // Depth is a power of two, so pointer overflow is the wrap.
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop1)   rd_ptr <= rd_ptr + AW'(1);

      case ({accept, pop1})
        2'b10:   skip_count <= skip_count + CW'(1);
        2'b01:   skip_count <= skip_count - CW'(1);
        default: skip_count <= skip_count;
      endcase
    end
  end

  // Storage is not reset; stale entries are never visible since the head is
  // masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= in_beat;
    end
  end

endmodule

// File: tb/tb_fixed_residual_fork.sv
module tb_fixed_residual_fork;

  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 8;

  typedef logic [N-1:0][W-1:0] beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din   [N-1:0];
  logic [W-1:0] dout0 [N-1:0];
  logic [W-1:0] dout1 [N-1:0];
  logic         in_valid, in_ready;
  logic         out0_valid, out0_ready;
  logic         out1_valid, out1_ready;
  logic [3:0]   skip_count;

  beat_t cur;
  beat_t q0 [$];
  beat_t q1 [$];
  beat_t e0, e1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) din[i] = cur[i];
  end

  fixed_residual_fork #(
    .DATA_IN_0_PRECISION_0(16), .DATA_IN_0_PRECISION_1(3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_1(1),
    .SKIP_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
    .data_out_0(dout0), .data_out_0_valid(out0_valid), .data_out_0_ready(out0_ready),
    .data_out_1(dout1), .data_out_1_valid(out1_valid), .data_out_1_ready(out1_ready),
    .skip_count(skip_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t pk(input logic [W-1:0] a [N-1:0]);
    beat_t b;
    for (int i = 0; i < N; i++) b[i] = a[i];
    return b;
  endfunction

  function automatic beat_t mkb(input int v);
    beat_t b;
    for (int i = 0; i < N; i++) b[i] = W'(v + (i << 8));
    return b;
  endfunction

  // Monitor: compares every beat handed to a consumer with the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("out0_unexpected_beat", 64'd1, 64'd0);
        else begin
          e0 = q0.pop_front();
          chk("out0_data", pk(dout0), e0);
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected_beat", 64'd1, 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("out1_data", pk(dout1), e1);
        end
      end
      if (skip_count > 4'(D)) chk("skip_count_bound", 64'(skip_count), 64'(D));
    end
  end

  // One clock of stimulus: handshake sampled mid-cycle, expected values
  // queued for both branches on acceptance.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      q0.push_back(cur);
      q1.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk(nm, 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    beat_t b;

    rst = 1'b1; in_valid = 1'b0; cur = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // 1. reset
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_out0_valid", 64'(out0_valid), 64'd0);
    chk("t1_out1_valid", 64'(out1_valid), 64'd0);
    chk("t1_skip_count", 64'(skip_count), 64'd0);
    chk("t1_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 2. single beat latency
    b[0] = 16'd1; b[1] = 16'd2; b[2] = 16'd3; b[3] = 16'd4;
    cur = b; in_valid = 1'b1;
    step(acc);
    chk("t2_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk("t2_out0_valid", 64'(out0_valid), 64'd1);
    chk("t2_out1_valid", 64'(out1_valid), 64'd1);
    chk("t2_out0_beat", pk(dout0), 64'h0004_0003_0002_0001);
    chk("t2_out1_beat", pk(dout1), 64'h0004_0003_0002_0001);
    step(acc);
    chk("t2_out0_idle", 64'(out0_valid), 64'd0);
    chk("t2_out1_idle", 64'(out1_valid), 64'd0);
    chk("t2_count_zero", 64'(skip_count), 64'd0);

    // 3. skip FIFO fills and blocks input
    out1_ready = 1'b0; out0_ready = 1'b1;
    n = 0; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cur = mkb(n);
      step(acc);
      if (acc) n++;
    end
    chk("t3_accepted", 64'(n), 64'd8);
    chk("t3_ready_full", 64'(in_ready), 64'd0);
    chk("t3_count_full", 64'(skip_count), 64'd8);
    out1_ready = 1'b1;
    step(acc);
    chk("t3_blocked_on_pop_cycle", 64'(acc), 64'd0);
    step(acc);
    chk("t3_resume", 64'(acc), 64'd1);
    if (acc) n++;
    while (n < 10) begin
      cur = mkb(n);
      step(acc);
      if (acc) n++;
    end
    in_valid = 1'b0;
    drain("t3_drain");

    // 4. main path stall
    out0_ready = 1'b0; out1_ready = 1'b0;
    cur = mkb(100); in_valid = 1'b1;
    step(acc);
    chk("t4_first_accept", 64'(acc), 64'd1);
    cur = mkb(101);
    step(acc);
    chk("t4_second_stalled", 64'(acc), 64'd0);
    chk("t4_count_one", 64'(skip_count), 64'd1);
    out0_ready = 1'b1;
    step(acc);
    chk("t4_accept_on_pop", 64'(acc), 64'd1);
    in_valid = 1'b0;
    drain("t4_drain");

    // 5. toggling skip consumer across pointer wraps
    out0_ready = 1'b1; out1_ready = 1'b0;
    n = 0; in_valid = 1'b1;
    for (int c = 0; c < 200 && n < 20; c++) begin
      cur = mkb(n);
      step(acc);
      if (acc) n++;
      out1_ready = ~out1_ready;
    end
    chk("t5_accepted", 64'(n), 64'd20);
    in_valid = 1'b0;
    drain("t5_drain");

    // 6. mid-operation reset
    out0_ready = 1'b1; out1_ready = 1'b0;
    n = 0; in_valid = 1'b1;
    for (int c = 0; c < 20 && n < 5; c++) begin
      cur = mkb(200 + n);
      step(acc);
      if (acc) n++;
    end
    out0_ready = 1'b0; in_valid = 1'b0;
    chk("t6_count_five", 64'(skip_count), 64'd5);
    chk("t6_f0_set", 64'(out0_valid), 64'd1);
    rst = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("t6_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("t6_out0_cleared", 64'(out0_valid), 64'd0);
    chk("t6_out1_cleared", 64'(out1_valid), 64'd0);
    chk("t6_count_cleared", 64'(skip_count), 64'd0);
    rst = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < N; i++) b[i] = 16'h00AA;
    cur = b; in_valid = 1'b1;
    step(acc);
    chk("t6_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk("t6_out0_first", pk(dout0), 64'h00AA_00AA_00AA_00AA);
    chk("t6_out1_first", pk(dout1), 64'h00AA_00AA_00AA_00AA);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
